fetch_stage: RTL and testbench

- Instruction fetch stage directly upstream of the control unit.
- Holds the fetch PC, issues requests to a variable-latency instruction memory (one request outstanding at a time) and buffers the response.
- Drives the IF/ID register, whose instr_d[6:0], [14:12] and [30] feed control's op, funct3 and funct7.
- Consumes control's PCsrc as redirect, with the target address computed in execute.

---
 rtl/fetch_stage_if.sv | 13 +
 rtl/fetch_stage.sv | 121 ++++++++++++
 tb/tb_fetch_stage.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Single outstanding request; memory always accepts a strobe.
interface fetch_stage_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_rvalid;
    logic [31:0]           imem_rdata;

    modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem request FSM, one-entry hold buffer and
// the IF/ID pipeline register feeding decode/control.
module fetch_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [31:0]           NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_stage_if.master         imem,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    input  logic                  stall_d,
    input  logic                  flush_d,
    output logic [31:0]           instr_d,
    output logic [ADDR_WIDTH-1:0] pc_d,
    output logic [ADDR_WIDTH-1:0] pc_plus4_d,
    output logic                  valid_d
);
    typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD} state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    state_t                r_state, w_next_state;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic                  r_kill;
    logic [31:0]           r_hold_instr;
    logic [ADDR_WIDTH-1:0] r_hold_pc;
    logic [31:0]           r_instr_d;
    logic [ADDR_WIDTH-1:0] r_pc_d, r_pc_plus4_d;
    logic                  r_valid_d;

    logic                  w_if_free, w_take, w_load_wait, w_load_hold, w_to_hold;
    logic [ADDR_WIDTH-1:0] w_target;

    assign w_target  = redirect_target & ~ADDR_WIDTH'(3);
    assign w_if_free = !r_valid_d || !stall_d;
    assign w_take    = (r_state == S_WAIT) && imem.imem_rvalid && !r_kill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_ISSUE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    if (redirect || r_kill || w_load_wait) w_next_state = S_ISSUE;
                    else                                   w_next_state = S_HOLD;
                end
            end
            S_HOLD:  if (redirect || w_load_hold) w_next_state = S_ISSUE;
            default: w_next_state = S_ISSUE;
        endcase
    end

    // Load strobes: redirect and flush both block any IF/ID load this cycle.
    always_comb begin
        imem.imem_req  = (r_state == S_ISSUE) && !rst;
        imem.imem_addr = r_fetch_pc;
        w_load_wait    = w_take && !redirect && !flush_d && w_if_free;
        w_load_hold    = (r_state == S_HOLD) && !redirect && !flush_d && w_if_free;
        w_to_hold      = w_take && !redirect && !w_load_wait;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc   <= RESET_PC;
            r_kill       <= 1'b0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
        end else if (redirect) begin
            r_fetch_pc <= w_target;
            // A request is still in flight unless its response lands this cycle.
            r_kill     <= (r_state == S_ISSUE) || (r_state == S_WAIT && !imem.imem_rvalid);
        end else begin
            if (r_state == S_WAIT && imem.imem_rvalid && r_kill) r_kill <= 1'b0;
            if (w_load_wait || w_load_hold) r_fetch_pc <= r_fetch_pc + PC_STEP;
            if (w_to_hold) begin
                r_hold_instr <= imem.imem_rdata;
                r_hold_pc    <= r_fetch_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else if (redirect || flush_d) begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else if (stall_d && r_valid_d) begin
            r_instr_d <= r_instr_d;
        end else if (w_load_wait) begin
            r_instr_d    <= imem.imem_rdata;
            r_pc_d       <= r_fetch_pc;
            r_pc_plus4_d <= r_fetch_pc + PC_STEP;
            r_valid_d    <= 1'b1;
        end else if (w_load_hold) begin
            r_instr_d    <= r_hold_instr;
            r_pc_d       <= r_hold_pc;
            r_pc_plus4_d <= r_hold_pc + PC_STEP;
            r_valid_d    <= 1'b1;
        end else begin
            // Decode consumed the entry and nothing new arrived: bubble.
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end
    end

    assign instr_d    = r_instr_d;
    assign pc_d       = r_pc_d;
    assign pc_plus4_d = r_pc_plus4_d;
    assign valid_d    = r_valid_d;
endmodule

// File: tb/tb_fetch_stage.sv
// Random-stimulus bench for fetch_stage: a transaction-level model tracks the
// next program-order PC and checks every delivered instruction and request.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if #(.ADDR_WIDTH(32)) imem ();

    logic        redirect = 1'b0, stall_d = 1'b0, flush_d = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
    logic        valid_d;

    fetch_stage #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .imem(imem),
        .redirect(redirect), .redirect_target(redirect_target),
        .stall_d(stall_d), .flush_d(flush_d),
        .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
    );

    int n_cmp = 0, n_err = 0;
    int it = 0, first_v = -1, second_v = -1, deliv = 0, gap = 0, gap_max = 0;
    int cnt = 0, stall_run = 0;
    bit pending = 0, rand_on = 0;
    logic [31:0] paddr = '0, exp_pc = '0;
    logic        p_redirect = 0, p_flush = 0, p_stall = 0, p_valid = 0;
    logic [31:0] p_target = '0, p_instr = '0, p_pc = '0, p_pc4 = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A13;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'b0, valid_d}, 32'h0);
        chk({tag, "_instr"}, instr_d, NOP);
        chk({tag, "_pc"}, pc_d, 32'h0);
        chk({tag, "_pc4"}, pc_plus4_d, 32'h0);
        chk({tag, "_req"}, {31'b0, imem.imem_req}, 32'h0);
        chk({tag, "_addr"}, imem.imem_addr, 32'h0);
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0103;
            1:       return 32'hFFFF_FFFC;
            2:       return 32'hFFFF_FFF8;
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        bit had;
        @(negedge clk);
        // IF/ID observed now reflects the inputs of the previous cycle
        if (p_redirect) begin
            exp_pc = p_target & ~32'h3;
            chk("redir_valid", {31'b0, valid_d}, 32'h0);
            chk("redir_instr", instr_d, NOP);
        end else if (p_flush) begin
            chk("flush_valid", {31'b0, valid_d}, 32'h0);
            chk("flush_instr", instr_d, NOP);
            chk("flush_pc", pc_d, p_pc);
        end else if (p_stall && p_valid) begin
            chk("stall_valid", {31'b0, valid_d}, 32'h1);
            chk("stall_instr", instr_d, p_instr);
            chk("stall_pc", pc_d, p_pc);
            chk("stall_pc4", pc_plus4_d, p_pc4);
        end else if (valid_d) begin
            chk("deliv_pc", pc_d, exp_pc);
            chk("deliv_instr", instr_d, mem_word(exp_pc));
            chk("deliv_pc4", pc_plus4_d, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            deliv++;
            gap = 0;
            if (first_v < 0) first_v = it;
            else if (second_v < 0) second_v = it;
        end else begin
            chk("bubble_instr", instr_d, NOP);
        end
        gap++;
        if (gap > gap_max) gap_max = gap;

        // memory model: variable latency, one response per accepted request
        imem.imem_rvalid = 1'b0;
        had = pending;
        if (pending) begin
            cnt--;
            if (cnt == 0) begin
                imem.imem_rvalid = 1'b1;
                imem.imem_rdata  = mem_word(paddr);
                pending = 0;
            end
        end
        if (imem.imem_req) begin
            chk("single_outst", {31'b0, had}, 32'h0);
            chk("req_addr", imem.imem_addr, exp_pc);
            pending = 1;
            paddr   = imem.imem_addr;
            cnt     = rand_on ? int'($urandom_range(1, 3)) : 1;
            if (rand_on && $urandom_range(0, 7) == 0) begin
                imem.imem_rvalid = 1'b1;
                imem.imem_rdata  = $urandom;
            end
        end

        redirect = 1'b0;
        flush_d  = 1'b0;
        stall_d  = 1'b0;
        if (rand_on) begin
            redirect = ($urandom_range(0, 19) == 0);
            if (redirect) redirect_target = pick_target();
            flush_d = ($urandom_range(0, 19) == 0);
            if (stall_run > 0) begin
                stall_run--;
                stall_d = 1'b1;
            end else if ($urandom_range(0, 5) == 0) begin
                stall_run = $urandom_range(0, 5);
                stall_d   = 1'b1;
            end
        end
        p_redirect = redirect;
        p_target   = redirect_target;
        p_flush    = flush_d;
        p_stall    = stall_d;
        p_valid    = valid_d;
        p_instr    = instr_d;
        p_pc       = pc_d;
        p_pc4      = pc_plus4_d;
        it++;
    endtask

    task automatic clear_model();
        pending = 0; cnt = 0; stall_run = 0;
        imem.imem_rvalid = 1'b0;
        redirect = 1'b0; flush_d = 1'b0; stall_d = 1'b0;
        p_redirect = 0; p_flush = 0; p_stall = 0; p_valid = 0;
        exp_pc = 32'h0;
    endtask

    initial begin
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");

        @(posedge clk);
        #1 rst = 1'b0;
        rand_on = 0;
        repeat (10) step();
        chk("lat_first", first_v, 32'd2);
        chk("lat_next", second_v, 32'd4);

        rand_on = 1;
        repeat (1500) step();

        for (int k = 0; k < 50 && !pending; k++) step();
        chk("wait_found", {31'b0, pending}, 32'h1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("midrst");
        clear_model();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (1500) step();

        chk("progress", {31'b0, deliv > 200}, 32'h1);
        chk("max_gap", {31'b0, gap_max <= 100}, 32'h1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
